pulp_io_l2_arbiter: RTL and testbench
=====================================

Name: pulp_io_l2_arbiter

Overview:
- Merges the uDMA read-only (ro) and write-only (wo) L2 requester ports onto a single TCDM-style L2 master port (req/gnt/rvalid protocol).
- Sits between udma_subsystem and the SoC interconnect in integrations that expose one L2 port.
- Round-robin arbitration with lock-until-grant.
- In-order response routing via an outstanding-transaction ID FIFO.

Parameters:
- L2_DATA_WIDTH, 32, data width of all ports; byte enables are L2_DATA_WIDTH/8 bits.
- L2_ADDR_WIDTH, 32, address width of all ports.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions; must be a power of 2 and ≥ 2.

Ports:
- sys_clk_i  in  1  clock
- sys_rst_i  in  1  asynchronous active-high reset
- ro_req_i / wo_req_i  in  1  requester request
- ro_gnt_o / wo_gnt_o  out  1  requester grant
- ro_wen_i / wo_wen_i  in  1  write enable, active-low (1 = read)
- ro_addr_i / wo_addr_i  in  L2_ADDR_WIDTH  address
- ro_be_i / wo_be_i  in  L2_DATA_WIDTH/8  byte enables
- ro_wdata_i / wo_wdata_i  in  L2_DATA_WIDTH  write data
- ro_rvalid_o / wo_rvalid_o  out  1  response valid
- ro_rdata_o / wo_rdata_o  out  L2_DATA_WIDTH  response data
- l2_req_o  out  1  master request
- l2_gnt_i  in  1  master grant
- l2_wen_o  out  1  master write enable (active-low)
- l2_addr_o  out  L2_ADDR_WIDTH  master address
- l2_be_o  out  L2_DATA_WIDTH/8  master byte enables
- l2_wdata_o  out  L2_DATA_WIDTH  master write data
- l2_rvalid_i  in  1  master response valid
- l2_rdata_i  in  L2_DATA_WIDTH  master response data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count
- err_o  out  1  sticky error: rvalid received with no outstanding transaction

Behaviour:
- Reset values: all outputs 0; RR pointer = ro; FSM = IDLE; FIFO empty.
- Reset is asynchronous and may assert mid-transfer; it drops all outstanding IDs.
- Requester protocol: req and its payload are held stable until gnt.
- Master protocol: l2_gnt_i is sampled in the same cycle as l2_req_o. rvalid arrives ≥ 1 cycle after gnt, in order.
- FSM states:
  - IDLE: winner = the single requester if only one requests; if both request, winner = RR pointer. If l2_gnt_i is low, go to HOLD(winner).
  - HOLD(w): selection frozen to w regardless of the other requester. Return to IDLE on grant.
  - A grant in IDLE stays in IDLE.
- RR pointer: on every handshake, pointer = the other requester. Pointer changes only on handshake.
- Stall: FIFO full → l2_req_o = 0 and no gnt forwarded. A full FIFO that pops this cycle does not release the stall; full is evaluated from the registered count.
- Mux: l2_req_o = (ro_req_i | wo_req_i) & ~full. Payload = selected requester's fields (combinational mux).
- Grant: {ro,wo}_gnt_o = l2_gnt_i & l2_req_o & selected. Combinational from l2_gnt_i; zero added latency.
- ID FIFO (1 bit per entry, 0 = ro, 1 = wo):
  - push on master handshake;
  - pop on l2_rvalid_i when not empty;
  - push and pop in the same cycle → count unchanged, both operations performed, including when count = MAX_OUTSTANDING. Pointers wrap modulo MAX_OUTSTANDING.
- Response: x_rvalid_o = l2_rvalid_i & ~empty & (head == x). rdata is broadcast: both rdata outputs = l2_rdata_i.
- l2_rvalid_i while empty: dropped, no rvalid_o, err_o set. err_o clears only on reset.
- outstanding_o is the registered count.
- Writes also occupy a FIFO slot; the L2 returns rvalid for writes.

Decomposition:
- pulp_io_l2_arb_pkg: typedef enum {ARB_IDLE, ARB_HOLD} arb_state_e; typedef enum logic {ID_RO = 0, ID_WO = 1} req_id_e.
- Sub-module pulp_io_l2_id_fifo: parametric depth, 1-bit entries. Exposes full, empty, count; supports simultaneous push/pop.

Test Plan:
- ro-only read to 0x1C00_0000 with gnt and rvalid 2 cycles later → ro_gnt_o same cycle; ro_rvalid_o 1 cycle with rdata 0xDEAD_BEEF; wo_rvalid_o never asserts.
- ro and wo request continuously, gnt always 1 → grants alternate ro, wo, ro, wo. Responses routed in grant order; outstanding_o ≤ 4.
- Both request, gnt low for 3 cycles while wo deasserts → l2_addr_o stays on ro's address for all 3 cycles (HOLD); ro granted when gnt rises.
- 4 grants with no rvalid → outstanding_o = 4, l2_req_o = 0 despite requests. A rvalid alone → count drops to 3 and requests resume the next cycle. rvalid plus new grant in the same cycle when count = 3 → count stays 3.
- l2_rvalid_i pulse with FIFO empty → no requester rvalid, err_o = 1 and held. sys_rst_i pulse → err_o = 0.
- Assert sys_rst_i asynchronously with 2 outstanding → outputs 0 immediately. After release, outstanding_o = 0 and the RR pointer is ro.

Source files
------------

// File: rtl/pulp_io_l2_arb_pkg.sv
// Shared types for the uDMA ro/wo -> single L2 port arbiter.
// Requester IDs double as the 1-bit tags stored in the outstanding-ID FIFO.
package pulp_io_l2_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

   typedef enum logic {ID_RO = 1'b0, ID_WO = 1'b1} req_id_e;

   function automatic req_id_e other_id(input req_id_e id);
      return (id == ID_RO) ? ID_WO : ID_RO;
   endfunction

endpackage

// File: rtl/pulp_io_l2_id_fifo.sv
// Outstanding-transaction tag FIFO: 1-bit entries, power-of-2 depth,
// simultaneous push/pop allowed at any fill level (including full).
module pulp_io_l2_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   din,
   output logic                   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // When full, a push is only legal because the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pulp_io_l2_arbiter.sv
// Merges the uDMA ro/wo L2 requesters onto one req/gnt/rvalid master port:
// round-robin with lock-until-grant, responses routed in order via a tag FIFO.
module pulp_io_l2_arbiter
   import pulp_io_l2_arb_pkg::*;
#(
   parameter int L2_DATA_WIDTH   = 32,
   parameter int L2_ADDR_WIDTH   = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             sys_clk_i,
   input  logic                             sys_rst_i,

   input  logic                             ro_req_i,
   output logic                             ro_gnt_o,
   input  logic                             ro_wen_i,
   input  logic [L2_ADDR_WIDTH-1:0]         ro_addr_i,
   input  logic [L2_DATA_WIDTH/8-1:0]       ro_be_i,
   input  logic [L2_DATA_WIDTH-1:0]         ro_wdata_i,
   output logic                             ro_rvalid_o,
   output logic [L2_DATA_WIDTH-1:0]         ro_rdata_o,

   input  logic                             wo_req_i,
   output logic                             wo_gnt_o,
   input  logic                             wo_wen_i,
   input  logic [L2_ADDR_WIDTH-1:0]         wo_addr_i,
   input  logic [L2_DATA_WIDTH/8-1:0]       wo_be_i,
   input  logic [L2_DATA_WIDTH-1:0]         wo_wdata_i,
   output logic                             wo_rvalid_o,
   output logic [L2_DATA_WIDTH-1:0]         wo_rdata_o,

   output logic                             l2_req_o,
   input  logic                             l2_gnt_i,
   output logic                             l2_wen_o,
   output logic [L2_ADDR_WIDTH-1:0]         l2_addr_o,
   output logic [L2_DATA_WIDTH/8-1:0]       l2_be_o,
   output logic [L2_DATA_WIDTH-1:0]         l2_wdata_o,
   input  logic                             l2_rvalid_i,
   input  logic [L2_DATA_WIDTH-1:0]         l2_rdata_i,

   output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
   output logic                             err_o
);

   localparam int BE_W = L2_DATA_WIDTH/8;

   typedef struct packed {
      logic                     wen;
      logic [L2_ADDR_WIDTH-1:0] addr;
      logic [BE_W-1:0]          be;
      logic [L2_DATA_WIDTH-1:0] wdata;
   } l2_req_t;

   l2_req_t    ro_pl, wo_pl, sel_pl;
   arb_state_e state;
   req_id_e    rr_ptr, hold_id, sel, head_id;
   logic       any_req, hs, full, empty, head;

   assign ro_pl   = '{wen: ro_wen_i, addr: ro_addr_i, be: ro_be_i, wdata: ro_wdata_i};
   assign wo_pl   = '{wen: wo_wen_i, addr: wo_addr_i, be: wo_be_i, wdata: wo_wdata_i};
   assign any_req = ro_req_i | wo_req_i;

   // Contested or idle cycles fall back to the RR pointer; HOLD overrides all.
   always_comb begin
      sel = rr_ptr;
      if (state == ARB_HOLD)
         sel = hold_id;
      else if (ro_req_i && !wo_req_i)
         sel = ID_RO;
      else if (wo_req_i && !ro_req_i)
         sel = ID_WO;
   end

   assign sel_pl     = (sel == ID_WO) ? wo_pl : ro_pl;
   assign l2_req_o   = any_req & ~full;
   assign l2_wen_o   = sel_pl.wen;
   assign l2_addr_o  = sel_pl.addr;
   assign l2_be_o    = sel_pl.be;
   assign l2_wdata_o = sel_pl.wdata;

   assign hs       = l2_req_o & l2_gnt_i;
   assign ro_gnt_o = hs & (sel == ID_RO);
   assign wo_gnt_o = hs & (sel == ID_WO);

   pulp_io_l2_id_fifo #(.DEPTH(MAX_OUTSTANDING)) i_id_fifo (
      .clk   (sys_clk_i),
      .rst   (sys_rst_i),
      .push  (hs),
      .pop   (l2_rvalid_i),
      .din   (sel == ID_WO),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (outstanding_o)
   );

   assign head_id     = req_id_e'(head);
   assign ro_rvalid_o = l2_rvalid_i & ~empty & (head_id == ID_RO);
   assign wo_rvalid_o = l2_rvalid_i & ~empty & (head_id == ID_WO);
   assign ro_rdata_o  = l2_rdata_i;
   assign wo_rdata_o  = l2_rdata_i;

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state   <= ARB_IDLE;
         hold_id <= ID_RO;
         rr_ptr  <= ID_RO;
         err_o   <= 1'b0;
      end else begin
         if (hs)
            rr_ptr <= other_id(sel);
         case (state)
            ARB_IDLE: if (any_req && !hs) begin
               state   <= ARB_HOLD;
               hold_id <= sel;
            end
            ARB_HOLD: if (hs) state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
         if (l2_rvalid_i && empty)
            err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pulp_io_l2_arbiter.sv
// Directed bench for pulp_io_l2_arbiter: inputs change just after the falling
// edge, outputs are checked 1 time unit later, mid-cycle.
module tb_pulp_io_l2_arbiter;

   localparam logic [31:0] RO_ADDR = 32'h1C00_0000;
   localparam logic [31:0] WO_ADDR = 32'h1C00_1000;

   logic        clk, rst;
   logic        ro_req, ro_gnt, ro_wen, ro_rvalid;
   logic [31:0] ro_addr, ro_wdata, ro_rdata;
   logic [3:0]  ro_be;
   logic        wo_req, wo_gnt, wo_wen, wo_rvalid;
   logic [31:0] wo_addr, wo_wdata, wo_rdata;
   logic [3:0]  wo_be;
   logic        l2_req, l2_gnt, l2_wen, l2_rvalid;
   logic [31:0] l2_addr, l2_wdata, l2_rdata;
   logic [3:0]  l2_be;
   logic [2:0]  outstanding;
   logic        err;

   int nvec = 0;
   int nerr = 0;

   pulp_io_l2_arbiter dut (
      .sys_clk_i(clk), .sys_rst_i(rst),
      .ro_req_i(ro_req), .ro_gnt_o(ro_gnt), .ro_wen_i(ro_wen), .ro_addr_i(ro_addr),
      .ro_be_i(ro_be), .ro_wdata_i(ro_wdata), .ro_rvalid_o(ro_rvalid), .ro_rdata_o(ro_rdata),
      .wo_req_i(wo_req), .wo_gnt_o(wo_gnt), .wo_wen_i(wo_wen), .wo_addr_i(wo_addr),
      .wo_be_i(wo_be), .wo_wdata_i(wo_wdata), .wo_rvalid_o(wo_rvalid), .wo_rdata_o(wo_rdata),
      .l2_req_o(l2_req), .l2_gnt_i(l2_gnt), .l2_wen_o(l2_wen), .l2_addr_o(l2_addr),
      .l2_be_o(l2_be), .l2_wdata_o(l2_wdata), .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata),
      .outstanding_o(outstanding), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rr, input logic wr, input logic g, input logic rv);
      @(negedge clk);
      ro_req = rr; wo_req = wr; l2_gnt = g; l2_rvalid = rv;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      ro_req = 0; ro_wen = 1'b1; ro_addr = RO_ADDR; ro_be = 4'hF; ro_wdata = '0;
      wo_req = 0; wo_wen = 1'b0; wo_addr = WO_ADDR; wo_be = 4'h3; wo_wdata = 32'h1234_5678;
      l2_gnt = 0; l2_rvalid = 0; l2_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rst_outstanding", 32'(outstanding), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_l2_req", 32'(l2_req), 0);
      chk("rst_rvalid", {30'd0, ro_rvalid, wo_rvalid}, 0);
      @(negedge clk); rst = 1'b0;

      // single ro read, response two cycles after grant
      drive(1, 0, 1, 0);
      chk("ro_only_req", 32'(l2_req), 1);
      chk("ro_only_addr", l2_addr, RO_ADDR);
      chk("ro_only_wen", 32'(l2_wen), 1);
      chk("ro_only_gnt", {30'd0, ro_gnt, wo_gnt}, 32'b10);
      drive(0, 0, 0, 0);
      chk("ro_only_outst", 32'(outstanding), 1);
      chk("ro_only_no_rv", {30'd0, ro_rvalid, wo_rvalid}, 0);
      drive(0, 0, 0, 1);
      chk("ro_only_rvalid", {30'd0, ro_rvalid, wo_rvalid}, 32'b10);
      chk("ro_only_rdata", ro_rdata, 32'hDEAD_BEEF);
      drive(0, 0, 0, 0);
      chk("ro_only_drain", 32'(outstanding), 0);
      chk("ro_only_rv_off", {30'd0, ro_rvalid, wo_rvalid}, 0);

      // both requesting; pointer now favours wo -> wo,ro,wo,ro,wo
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 1, k > 0);
         chk("rr_gnt", {30'd0, ro_gnt, wo_gnt}, (k % 2 == 0) ? 32'b01 : 32'b10);
         chk("rr_addr", l2_addr, (k % 2 == 0) ? WO_ADDR : RO_ADDR);
         chk("rr_outst", 32'(outstanding), (k == 0) ? 0 : 1);
         if (k > 0)
            chk("rr_route", {30'd0, ro_rvalid, wo_rvalid}, (k % 2 == 1) ? 32'b01 : 32'b10);
      end
      drive(0, 0, 0, 1);
      chk("rr_last_route", {30'd0, ro_rvalid, wo_rvalid}, 32'b01);
      drive(0, 0, 0, 0);
      chk("rr_drained", 32'(outstanding), 0);

      // HOLD: pointer is ro, gnt low three cycles, wo drops away meanwhile
      drive(1, 1, 0, 0);
      chk("hold_addr0", l2_addr, RO_ADDR);
      chk("hold_gnt0", {30'd0, ro_gnt, wo_gnt}, 0);
      drive(1, 1, 0, 0);
      chk("hold_addr1", l2_addr, RO_ADDR);
      drive(1, 0, 0, 0);
      chk("hold_addr2", l2_addr, RO_ADDR);
      chk("hold_req2", 32'(l2_req), 1);
      drive(1, 0, 1, 0);
      chk("hold_gnt", {30'd0, ro_gnt, wo_gnt}, 32'b10);
      drive(0, 0, 0, 1);
      chk("hold_route", {30'd0, ro_rvalid, wo_rvalid}, 32'b10);

      // fill the FIFO: pointer is wo -> wo,ro,wo,ro
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 1, 0);
         chk("fill_outst", 32'(outstanding), k);
         chk("fill_gnt", {30'd0, ro_gnt, wo_gnt}, (k % 2 == 0) ? 32'b01 : 32'b10);
      end
      drive(1, 1, 1, 0);
      chk("full_outst", 32'(outstanding), 4);
      chk("full_stall_req", 32'(l2_req), 0);
      chk("full_stall_gnt", {30'd0, ro_gnt, wo_gnt}, 0);
      drive(1, 1, 1, 1);
      chk("full_pop_still_stalled", 32'(l2_req), 0);
      chk("full_pop_route", {30'd0, ro_rvalid, wo_rvalid}, 32'b01);
      drive(1, 1, 0, 0);
      chk("resume_outst", 32'(outstanding), 3);
      chk("resume_req", 32'(l2_req), 1);
      chk("resume_addr", l2_addr, WO_ADDR);
      drive(1, 1, 1, 1);
      chk("pushpop_gnt", {30'd0, ro_gnt, wo_gnt}, 32'b01);
      chk("pushpop_route", {30'd0, ro_rvalid, wo_rvalid}, 32'b10);
      drive(0, 0, 0, 0);
      chk("pushpop_outst", 32'(outstanding), 3);
      drive(0, 0, 0, 1);
      chk("pre_rst_route", {30'd0, ro_rvalid, wo_rvalid}, 32'b01);

      // async reset mid-cycle with 2 outstanding
      drive(0, 0, 0, 0);
      chk("pre_rst_outst", 32'(outstanding), 2);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outst", 32'(outstanding), 0);
      chk("async_rst_err", 32'(err), 0);
      @(negedge clk); rst = 1'b0;
      drive(1, 1, 1, 0);
      chk("post_rst_rr_ro", {30'd0, ro_gnt, wo_gnt}, 32'b10);
      drive(0, 0, 0, 1);
      chk("post_rst_route", {30'd0, ro_rvalid, wo_rvalid}, 32'b10);

      // rvalid with nothing outstanding
      drive(0, 0, 0, 1);
      chk("empty_rv_dropped", {30'd0, ro_rvalid, wo_rvalid}, 0);
      drive(0, 0, 0, 0);
      chk("err_set", 32'(err), 1);
      chk("err_outst", 32'(outstanding), 0);
      drive(0, 0, 0, 0);
      chk("err_held", 32'(err), 1);
      @(negedge clk); rst = 1'b1;
      #1;
      chk("err_cleared", 32'(err), 0);
      @(negedge clk); rst = 1'b0;
      drive(0, 0, 0, 0);
      chk("err_stays_clear", 32'(err), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
